if_id_skid_reg: RTL and testbench

- Downstream neighbour of the 64-bit {pc, instr} concatenation stage in the pipelined core.
- Consumes the concatenated word {pc[63:32], instr[31:0]} and registers it into the IF/ID boundary through a 2-entry skid buffer with valid/ready handshake and flush.
- Splits the word back into pc and instr for decode.
- Inserts NOP on bubbles and counts entries discarded by flush.

---
 rtl/if_id_skid_reg.sv | 123 ++++++++++++
 tb/tb_if_id_skid_reg.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// IF/ID boundary register: 2-entry skid buffer that splits {pc, instr}
// for decode, inserts NOPs on bubbles and counts flush-discarded entries.
module if_id_skid_reg #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013,
    parameter int              CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [2*XLEN-1:0] in_data,
    output logic              in_ready,
    input  logic              out_ready,
    input  logic              flush,
    output logic              out_valid,
    output logic [XLEN-1:0]   out_pc,
    output logic [XLEN-1:0]   out_instr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_drops
);

    localparam logic [2*XLEN-1:0] EMPTY_E = {{XLEN{1'b0}}, NOP_INSTR};
    localparam logic [CNT_W-1:0]  MAX_CNT = {CNT_W{1'b1}};

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_FULL  = 2'd2;

    logic [2*XLEN-1:0] main_q, main_d;
    logic [2*XLEN-1:0] skid_q, skid_d;
    logic [1:0]        occ_q, occ_d;
    logic              valid_q, valid_d;
    logic              ready_q, ready_d;
    logic [CNT_W-1:0]  drops_q, drops_d;

    logic              push;
    logic              pop;
    logic [2:0]        lost;
    logic [CNT_W:0]    drops_sum;

    assign push = in_valid & ready_q;
    assign pop  = valid_q & out_ready;

    // Entries destroyed by a flush: whatever stays behind plus the new word.
    always_comb begin
        lost      = {1'b0, occ_q} - {2'b00, pop} + {2'b00, push};
        drops_sum = {1'b0, drops_q} + (CNT_W+1)'(lost);
    end

    always_comb begin
        main_d  = main_q;
        skid_d  = skid_q;
        occ_d   = occ_q;
        drops_d = drops_q;
        if (flush) begin
            main_d  = EMPTY_E;
            skid_d  = EMPTY_E;
            occ_d   = OCC_EMPTY;
            drops_d = (drops_sum > {1'b0, MAX_CNT}) ? MAX_CNT
                                                    : drops_sum[CNT_W-1:0];
        end else begin
            unique case (occ_q)
                OCC_EMPTY: begin
                    if (push) begin
                        main_d = in_data;
                        occ_d  = OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        skid_d = in_data;
                        occ_d  = OCC_FULL;
                    end else if (pop) begin
                        main_d = EMPTY_E;
                        occ_d  = OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (pop) begin
                        main_d = skid_q;
                        skid_d = EMPTY_E;
                        occ_d  = OCC_ONE;
                    end
                end
                default: begin
                    main_d = EMPTY_E;
                    skid_d = EMPTY_E;
                    occ_d  = OCC_EMPTY;
                end
            endcase
        end
        valid_d = (occ_d != OCC_EMPTY);
        ready_d = (occ_d != OCC_FULL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            main_q  <= EMPTY_E;
            skid_q  <= EMPTY_E;
            occ_q   <= OCC_EMPTY;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            drops_q <= '0;
        end else begin
            main_q  <= main_d;
            skid_q  <= skid_d;
            occ_q   <= occ_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
            drops_q <= drops_d;
        end
    end

    assign in_ready    = ready_q;
    assign out_valid   = valid_q;
    assign occupancy   = occ_q;
    assign out_pc      = main_q[2*XLEN-1:XLEN];
    assign out_instr   = main_q[XLEN-1:0];
    assign flush_drops = drops_q;

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: vector table, scoreboard monitor and
// hand-written corner sequences (streaming, async reset, saturation).
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, out_ready, flush;
    logic [63:0] in_data;
    logic        in_ready, out_valid;
    logic [31:0] out_pc, out_instr;
    logic [1:0]  occupancy;
    logic [7:0]  flush_drops;

    logic        iv2, or2, fl2;
    logic [63:0] d2;
    logic        rdy2, v2;
    logic [31:0] pc2, ins2;
    logic [1:0]  occ2;
    logic [1:0]  drops2;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] sb[$];

    always #5 clk = ~clk;

    if_id_skid_reg dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_ready(out_ready), .flush(flush),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .occupancy(occupancy), .flush_drops(flush_drops)
    );

    if_id_skid_reg #(.CNT_W(2)) dut2 (
        .clk(clk), .reset(reset),
        .in_valid(iv2), .in_data(d2), .in_ready(rdy2),
        .out_ready(or2), .flush(fl2),
        .out_valid(v2), .out_pc(pc2), .out_instr(ins2),
        .occupancy(occ2), .flush_drops(drops2)
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Scoreboard: accepted words are queued, popped words compared in order.
    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_pop: got %h expected nothing",
                             {out_pc, out_instr});
                end else begin
                    chk("sb_data", {out_pc, out_instr}, sb.pop_front());
                end
            end
            if (in_valid && in_ready) sb.push_back(in_data);
            if (flush) sb.delete();
        end
    end

    typedef struct {
        logic        iv;
        logic [63:0] d;
        logic        ordy;
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] ein;
        logic [1:0]  eocc;
        logic        erdy;
        logic [7:0]  edrops;
    } vec_t;

    vec_t vecs[17];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [63:0] d,
                         input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0]  = '{1, 64'h00000004_00A00093, 1, 0, 1, 32'h4,  32'h00A00093, 1, 1, 0};
        vecs[1]  = '{0, 64'h0,                 1, 0, 0, 32'h0,  NOP,          0, 1, 0};
        vecs[2]  = '{1, 64'h00000000_11111111, 0, 0, 1, 32'h0,  32'h11111111, 1, 1, 0};
        vecs[3]  = '{1, 64'h00000004_22222222, 0, 0, 1, 32'h0,  32'h11111111, 2, 0, 0};
        vecs[4]  = '{1, 64'h00000008_33333333, 0, 0, 1, 32'h0,  32'h11111111, 2, 0, 0};
        vecs[5]  = '{0, 64'h0,                 1, 0, 1, 32'h4,  32'h22222222, 1, 1, 0};
        vecs[6]  = '{0, 64'h0,                 1, 0, 0, 32'h0,  NOP,          0, 1, 0};
        vecs[7]  = '{1, 64'h00000010_AAAAAAAA, 0, 0, 1, 32'h10, 32'hAAAAAAAA, 1, 1, 0};
        vecs[8]  = '{1, 64'h00000014_BBBBBBBB, 0, 0, 1, 32'h10, 32'hAAAAAAAA, 2, 0, 0};
        vecs[9]  = '{1, 64'h00000018_CCCCCCCC, 0, 1, 0, 32'h0,  NOP,          0, 1, 2};
        vecs[10] = '{1, 64'h00000020_DDDDDDDD, 0, 0, 1, 32'h20, 32'hDDDDDDDD, 1, 1, 2};
        vecs[11] = '{1, 64'h00000024_EEEEEEEE, 0, 1, 0, 32'h0,  NOP,          0, 1, 4};
        vecs[12] = '{1, 64'h00000028_12345678, 1, 0, 1, 32'h28, 32'h12345678, 1, 1, 4};
        vecs[13] = '{1, 64'h0000002C_9ABCDEF0, 1, 1, 0, 32'h0,  NOP,          0, 1, 5};
        vecs[14] = '{0, 64'h0,                 0, 1, 0, 32'h0,  NOP,          0, 1, 5};
        vecs[15] = '{1, 64'h00000030_0BADF00D, 1, 0, 1, 32'h30, 32'h0BADF00D, 1, 1, 5};
        vecs[16] = '{0, 64'h0,                 1, 1, 0, 32'h0,  NOP,          0, 1, 5};

        reset = 1'b1;
        drive(0, 64'h0, 0, 0);
        iv2 = 0; d2 = '0; or2 = 0; fl2 = 0;
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_occ", occupancy, 0);
        chk("rst_pc", out_pc, 0);
        chk("rst_instr", out_instr, NOP);
        chk("rst_drops", flush_drops, 0);
        step();
        reset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].fl);
            step();
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].ev);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].epc);
            chk($sformatf("v%0d_instr", i), out_instr, vecs[i].ein);
            chk($sformatf("v%0d_occ", i), occupancy, vecs[i].eocc);
            chk($sformatf("v%0d_ready", i), in_ready, vecs[i].erdy);
            chk($sformatf("v%0d_drops", i), flush_drops, vecs[i].edrops);
        end

        // Back-to-back streaming: one-cycle latency, no bubbles.
        for (int i = 0; i <= 10; i++) begin
            drive(1, {32'(i * 4), 32'h10000000 + 32'(i)}, 1, 0);
            step();
            chk($sformatf("st%0d_valid", i), out_valid, 1);
            chk($sformatf("st%0d_pc", i), out_pc, 32'(i * 4));
            chk($sformatf("st%0d_occ", i), occupancy, 1);
            chk($sformatf("st%0d_ready", i), in_ready, 1);
        end
        drive(0, 64'h0, 1, 0);
        step();
        chk("st_drain_valid", out_valid, 0);
        chk("sb_left", 64'(sb.size()), 0);

        // Async reset while FULL, no clock edge in between.
        drive(1, 64'h00000040_44444444, 0, 0);
        step();
        drive(1, 64'h00000044_55555555, 0, 0);
        step();
        drive(0, 64'h0, 0, 0);
        chk("full_occ", occupancy, 2);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_ready", in_ready, 1);
        chk("arst_occ", occupancy, 0);
        chk("arst_instr", out_instr, NOP);
        chk("arst_drops", flush_drops, 0);
        #4;
        reset = 1'b0;
        step();

        // Saturating drop counter on the CNT_W=2 instance.
        for (int k = 0; k < 4; k++) begin
            iv2 = 1; d2 = {32'h100, 32'h66666666}; or2 = 0; fl2 = 0;
            step();
            d2 = {32'h104, 32'h77777777};
            step();
            chk($sformatf("sat%0d_full", k), occ2, 2);
            iv2 = 0; fl2 = 1;
            step();
            fl2 = 0;
            chk($sformatf("sat%0d_occ", k), occ2, 0);
            chk($sformatf("sat%0d_drops", k), drops2, (k == 0) ? 2 : 3);
        end
        step();
        chk("sat_hold", drops2, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
